// File: rtl/clint_timer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | clint_timer: msip / mtime / mtimecmp register block plus ext-irq sync.     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module clint_timer #(
  parameter int TICK_DIV = 1,
  parameter int ADDR_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [63:0]       wdata_i,
  input  logic [7:0]        wmask_i,
  output logic              ack_o,
  output logic [63:0]       rdata_o,
  output logic              err_o,
  input  logic              ext_irq_pin_i,
  output logic              ext_irq_o,
  output logic              sft_irq_o,
  output logic              tmr_irq_o
);

  localparam logic [15:0]       TICK_LAST     = 16'(TICK_DIV - 1);
  localparam logic [ADDR_W-1:0] ADDR_MSIP     = ADDR_W'(32'h0000);
  localparam logic [ADDR_W-1:0] ADDR_MTIMECMP = ADDR_W'(32'h4000);
  localparam logic [ADDR_W-1:0] ADDR_MTIME    = ADDR_W'(32'hBFF8);

  logic [15:0] presc_q, presc_d;
  logic [63:0] mtime_q, mtime_d;
  logic [63:0] mtimecmp_q, mtimecmp_d;
  logic        msip_q, msip_d;
  logic        ack_q, ack_d;
  logic [63:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        tmr_q, tmr_d;
  logic        ext_s1_q, ext_s1_d;
  logic        ext_s2_q, ext_s2_d;

  logic        tick;
  logic        sel_msip, sel_cmp, sel_mtime, wr, rd;
  logic [63:0] rd_mux;
  logic        unused_addr_lo;

  // Registers are 8-byte aligned, so the low offset bits never select anything.
  assign unused_addr_lo = ^addr_i[2:0];

  assign tick      = (presc_q == TICK_LAST);
  assign sel_msip  = (addr_i[ADDR_W-1:3] == ADDR_MSIP[ADDR_W-1:3]);
  assign sel_cmp   = (addr_i[ADDR_W-1:3] == ADDR_MTIMECMP[ADDR_W-1:3]);
  assign sel_mtime = (addr_i[ADDR_W-1:3] == ADDR_MTIME[ADDR_W-1:3]);
  assign wr        = req_i & we_i;
  assign rd        = req_i & ~we_i;

  always_comb begin
    presc_d    = tick ? 16'd0 : presc_q + 16'd1;
    mtime_d    = mtime_q + {63'd0, tick};
    mtimecmp_d = mtimecmp_q;
    msip_d     = msip_q;
    // Byte writes to mtime merge onto the already-incremented value.
    for (int b = 0; b < 8; b++) begin
      if (wmask_i[b]) begin
        if (wr && sel_mtime) mtime_d[8*b +: 8]    = wdata_i[8*b +: 8];
        if (wr && sel_cmp)   mtimecmp_d[8*b +: 8] = wdata_i[8*b +: 8];
      end
    end
    if (wr && sel_msip && wmask_i[0]) msip_d = wdata_i[0];

    rd_mux = 64'd0;
    if (sel_msip)       rd_mux = {63'd0, msip_q};
    else if (sel_cmp)   rd_mux = mtimecmp_q;
    else if (sel_mtime) rd_mux = mtime_q;

    ack_d    = req_i;
    rdata_d  = rd ? rd_mux : 64'd0;
    err_d    = req_i & ~(sel_msip | sel_cmp | sel_mtime);
    tmr_d    = (mtime_q >= mtimecmp_q);
    ext_s1_d = ext_irq_pin_i;
    ext_s2_d = ext_s1_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q    <= 16'd0;
      mtime_q    <= 64'd0;
      mtimecmp_q <= 64'hFFFF_FFFF_FFFF_FFFF;
      msip_q     <= 1'b0;
      ack_q      <= 1'b0;
      rdata_q    <= 64'd0;
      err_q      <= 1'b0;
      tmr_q      <= 1'b0;
      ext_s1_q   <= 1'b0;
      ext_s2_q   <= 1'b0;
    end else begin
      presc_q    <= presc_d;
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      msip_q     <= msip_d;
      ack_q      <= ack_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
      tmr_q      <= tmr_d;
      ext_s1_q   <= ext_s1_d;
      ext_s2_q   <= ext_s2_d;
    end
  end

  assign ack_o     = ack_q;
  assign rdata_o   = rdata_q;
  assign err_o     = err_q;
  assign tmr_irq_o = tmr_q;
  assign sft_irq_o = msip_q;
  assign ext_irq_o = ext_s2_q;

endmodule
`default_nettype wire

// File: tb/tb_clint_timer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_clint_timer: two instances (TICK_DIV 1 and 4) against a reference model. |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_clint_timer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0, we = 1'b0, pin = 1'b0;
  logic [15:0] addr = 16'd0;
  logic [63:0] wdata = 64'd0;
  logic [7:0]  wmask = 8'd0;

  logic        ack [2];
  logic [63:0] rdata [2];
  logic        err [2], ext [2], sft [2], tmr [2];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  clint_timer #(.TICK_DIV(1), .ADDR_W(16)) u_div1 (
    .clk(clk), .rst_n(rst_n), .req_i(req), .we_i(we), .addr_i(addr),
    .wdata_i(wdata), .wmask_i(wmask), .ack_o(ack[0]), .rdata_o(rdata[0]),
    .err_o(err[0]), .ext_irq_pin_i(pin), .ext_irq_o(ext[0]),
    .sft_irq_o(sft[0]), .tmr_irq_o(tmr[0]));

  clint_timer #(.TICK_DIV(4), .ADDR_W(16)) u_div4 (
    .clk(clk), .rst_n(rst_n), .req_i(req), .we_i(we), .addr_i(addr),
    .wdata_i(wdata), .wmask_i(wmask), .ack_o(ack[1]), .rdata_o(rdata[1]),
    .err_o(err[1]), .ext_irq_pin_i(pin), .ext_irq_o(ext[1]),
    .sft_irq_o(sft[1]), .tmr_irq_o(tmr[1]));

  // Reference model: architectural register contents plus edge count since reset.
  int unsigned div [2] = '{1, 4};
  logic [63:0] m_mtime [2], m_cmp [2];
  logic        m_msip [2];
  int unsigned m_cyc [2];
  logic        e_ack, e_err, e_tmr [2];
  logic [63:0] e_rdata [2];
  logic [1:0]  pin_hist;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] d,
                                        input logic [7:0] m);
    logic [63:0] r = old;
    for (int b = 0; b < 8; b++) if (m[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_mtime[k] = 64'd0; m_cmp[k] = '1; m_msip[k] = 1'b0; m_cyc[k] = 0;
      e_tmr[k] = 1'b0; e_rdata[k] = 64'd0;
    end
    e_ack = 1'b0; e_err = 1'b0; pin_hist = 2'b00;
  endtask

  task automatic model_step();
    logic [15:0] base;
    logic [63:0] rv, nt;
    base  = addr & 16'hFFF8;
    e_ack = req;
    e_err = req && !(base == 16'h0000 || base == 16'h4000 || base == 16'hBFF8);
    for (int k = 0; k < 2; k++) begin
      rv = (base == 16'h0000) ? {63'd0, m_msip[k]} :
           (base == 16'h4000) ? m_cmp[k] :
           (base == 16'hBFF8) ? m_mtime[k] : 64'd0;
      e_rdata[k] = (req && !we) ? rv : 64'd0;
      e_tmr[k]   = (m_mtime[k] >= m_cmp[k]);
      nt = m_mtime[k] + (((m_cyc[k] % div[k]) == div[k] - 1) ? 64'd1 : 64'd0);
      if (req && we) begin
        if (base == 16'h0000 && wmask[0]) m_msip[k] = wdata[0];
        if (base == 16'h4000) m_cmp[k] = merge(m_cmp[k], wdata, wmask);
        if (base == 16'hBFF8) nt = merge(nt, wdata, wmask);
      end
      m_mtime[k] = nt;
      m_cyc[k]++;
    end
    pin_hist = {pin_hist[0], pin};
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      if (rst_n) model_step();
      @(negedge clk);
      if (!rst_n) model_reset();
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("ack%0d", k),   {63'd0, ack[k]}, {63'd0, e_ack});
        chk($sformatf("rdata%0d", k), rdata[k],        e_rdata[k]);
        chk($sformatf("err%0d", k),   {63'd0, err[k]}, {63'd0, e_err});
        chk($sformatf("tmr%0d", k),   {63'd0, tmr[k]}, {63'd0, e_tmr[k]});
        chk($sformatf("sft%0d", k),   {63'd0, sft[k]}, {63'd0, m_msip[k]});
        chk($sformatf("ext%0d", k),   {63'd0, ext[k]}, {63'd0, pin_hist[1]});
      end
    end
  end

  task automatic idle(input int n);
    req = 1'b0; we = 1'b0;
    repeat (n) begin @(negedge clk); #1; end
  endtask

  // Issues one request; on return its ack/rdata/err are visible.
  task automatic bus(input logic w, input logic [15:0] a, input logic [63:0] d,
                     input logic [7:0] m);
    req = 1'b1; we = w; addr = a; wdata = d; wmask = m;
    @(negedge clk); #1;
  endtask

  initial begin
    int guard;
    logic [15:0] a;
    logic [63:0] d;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;

    idle(5);
    bus(0, 16'hBFF8, 0, 0);
    chk("lit_mtime_after5_div1", rdata[0], 64'd5);
    chk("lit_mtime_after5_div4", rdata[1], 64'd1);

    bus(1, 16'h0000, 64'd1, 8'hFF);
    chk("lit_sft_set", {63'd0, sft[0]}, 64'd1);
    bus(0, 16'h0000, 0, 0);
    chk("lit_msip_read1", rdata[0], 64'd1);
    bus(1, 16'h0000, 64'd0, 8'hFF);
    chk("lit_sft_clr", {63'd0, sft[0]}, 64'd0);
    bus(0, 16'h0000, 0, 0);
    chk("lit_msip_read0", rdata[0], 64'd0);

    bus(1, 16'hBFF8, 64'd10, 8'hFF);
    bus(1, 16'h4000, 64'd20, 8'hFF);
    idle(9);
    chk("lit_tmr_before", {63'd0, tmr[0]}, 64'd0);
    idle(1);
    chk("lit_tmr_rise", {63'd0, tmr[0]}, 64'd1);
    bus(1, 16'h4000, '1, 8'hFF);
    chk("lit_tmr_lag", {63'd0, tmr[0]}, 64'd1);
    idle(1);
    chk("lit_tmr_clear", {63'd0, tmr[0]}, 64'd0);

    bus(1, 16'h4000, 64'd2, 8'hFF);
    guard = 0;
    while ((m_cyc[1] % 4) != 0 && guard < 8) begin idle(1); guard++; end
    bus(1, 16'hBFF8, 64'hFFFF_FFFF_FFFF_FFFE, 8'hFF);
    idle(7);
    bus(0, 16'hBFF8, 0, 0);
    chk("lit_wrap_div4", rdata[1], 64'd0);
    chk("lit_wrap_div1", rdata[0], 64'd5);

    bus(1, 16'hBFF8, 64'h1_0000_00FF, 8'hFF);
    bus(1, 16'hBFF8, 64'd0, 8'h0F);
    bus(0, 16'hBFF8, 0, 0);
    chk("lit_mask_on_tick", rdata[0], 64'h1_0000_0000);
    bus(0, 16'h1234, 0, 0);
    chk("lit_unmapped_err", {63'd0, err[0]}, 64'd1);
    chk("lit_unmapped_rdata", rdata[0], 64'd0);

    pin = 1'b1;
    idle(1);
    chk("lit_ext_lat1", {63'd0, ext[0]}, 64'd0);
    idle(1);
    chk("lit_ext_lat2", {63'd0, ext[0]}, 64'd1);
    idle(1);
    pin = 1'b0;
    idle(3);

    repeat (400) begin
      if ($urandom_range(0, 3) == 0) idle(1);
      else begin
        case ($urandom_range(0, 3))
          0: a = 16'h0000 | 16'($urandom_range(0, 7));
          1: a = 16'h4000 | 16'($urandom_range(0, 7));
          2: a = 16'hBFF8 | 16'($urandom_range(0, 7));
          default: a = 16'($urandom);
        endcase
        if ($urandom_range(0, 1) == 1) d = m_mtime[0] + 64'($urandom_range(0, 8)) - 64'd4;
        else d = {$urandom, $urandom};
        pin = 1'($urandom);
        bus(1'($urandom), a, d, ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom));
      end
    end
    pin = 1'b0;

    bus(1, 16'h0000, 64'd1, 8'hFF);
    req = 1'b1; we = 1'b0; addr = 16'hBFF8;
    #2 rst_n = 1'b0;
    @(negedge clk); #1;
    req = 1'b0;
    chk("lit_rst_no_ack", {63'd0, ack[0]}, 64'd0);
    chk("lit_rst_sft", {63'd0, sft[0]}, 64'd0);
    idle(2);
    rst_n = 1'b1;
    idle(1);
    chk("lit_rst_ack_after", {63'd0, ack[0]}, 64'd0);
    bus(0, 16'h4000, 0, 0);
    chk("lit_rst_cmp", rdata[0], 64'hFFFF_FFFF_FFFF_FFFF);
    bus(0, 16'h0000, 0, 0);
    chk("lit_rst_msip", rdata[0], 64'd0);
    bus(0, 16'hBFF8, 0, 0);
    chk("lit_rst_mtime_div1", rdata[0], 64'd3);
    chk("lit_rst_mtime_div4", rdata[1], 64'd0);
    idle(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
